// File: rtl/csc_share_arb.sv
// csc_share_arb: time-shares one CSC core between two pixel streams (A, B).
// Each port has a one-entry holding register. A round-robin arbiter issues at
// most one pixel per clock to the CSC. A tag pipe matched to the CSC latency
// carries {valid, id, user}, and CSC results are steered to per-port output
// registers.
module csc_share_arb #(
  parameter int DW      = 12,
  parameter int CSC_LAT = 4,
  parameter int UW      = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [3*DW-1:0] a_data,
  input  logic [UW-1:0]   a_user,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [3*DW-1:0] b_data,
  input  logic [UW-1:0]   b_user,
  input  logic            b_valid,
  output logic            b_ready,
  output logic [DW-1:0]   csc_din0,
  output logic [DW-1:0]   csc_din1,
  output logic [DW-1:0]   csc_din2,
  input  logic [DW-1:0]   csc_dout0,
  input  logic [DW-1:0]   csc_dout1,
  input  logic [DW-1:0]   csc_dout2,
  output logic [3*DW-1:0] a_out_data,
  output logic [UW-1:0]   a_out_user,
  output logic            a_out_valid,
  output logic [3*DW-1:0] b_out_data,
  output logic [UW-1:0]   b_out_user,
  output logic            b_out_valid
);

  localparam int NP = 2;  // index 0 = port A, 1 = port B

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} rr_t;

  rr_t             r_rr;
  rr_t             w_rr_next;

  logic [3*DW-1:0] w_in_data   [NP];
  logic [UW-1:0]   w_in_user   [NP];
  logic [NP-1:0]   w_in_valid;
  logic [NP-1:0]   w_ready;
  logic [NP-1:0]   w_full;
  logic [NP-1:0]   w_grant;
  logic [3*DW-1:0] w_hold_data [NP];
  logic [UW-1:0]   w_hold_user [NP];

  logic [3*DW-1:0] w_sel_data;
  logic [UW-1:0]   w_sel_user;

  logic [3*DW-1:0] r_din;
  logic            r_issue_vld;
  logic            r_issue_id;
  logic [UW-1:0]   r_issue_user;

  logic            r_tag_vld  [CSC_LAT];
  logic            r_tag_id   [CSC_LAT];
  logic [UW-1:0]   r_tag_user [CSC_LAT];

  logic [3*DW-1:0] w_dout;
  logic [3*DW-1:0] w_out_data  [NP];
  logic [UW-1:0]   w_out_user  [NP];
  logic [NP-1:0]   w_out_valid;

  assign w_in_data[0] = a_data;
  assign w_in_data[1] = b_data;
  assign w_in_user[0] = a_user;
  assign w_in_user[1] = b_user;
  assign w_in_valid   = {b_valid, a_valid};
  assign a_ready      = w_ready[0];
  assign b_ready      = w_ready[1];

  genvar gi;

  // Per-port one-entry holding register
  generate
    for (gi = 0; gi < NP; gi++) begin : g_hold
      logic            r_full;
      logic [3*DW-1:0] r_data;
      logic [UW-1:0]   r_user;

      // Ready when empty or being drained this cycle; forced low during reset
      assign w_ready[gi]     = rstn & (~r_full | w_grant[gi]);
      assign w_full[gi]      = r_full;
      assign w_hold_data[gi] = r_data;
      assign w_hold_user[gi] = r_user;

      // Capture on handshake (a refill beats the drain), empty on grant
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_full <= 1'b0;
          r_data <= '0;
          r_user <= '0;
        end else if (w_in_valid[gi] && w_ready[gi]) begin
          r_full <= 1'b1;
          r_data <= w_in_data[gi];
          r_user <= w_in_user[gi];
        end else if (w_grant[gi]) begin
          r_full <= 1'b0;
        end
      end
    end
  endgenerate

  // Round-robin pointer register, remembers which port was granted last
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rr <= LAST_B;
    else       r_rr <= w_rr_next;
  end

  // Arbiter: lone candidate wins; on conflict the port not granted last wins
  always_comb begin
    w_grant   = '0;
    w_rr_next = r_rr;
    if (w_full[0] && (!w_full[1] || r_rr == LAST_B)) begin
      w_grant[0] = 1'b1;
    end else if (w_full[1]) begin
      w_grant[1] = 1'b1;
    end
    if (w_grant[0])      w_rr_next = LAST_A;
    else if (w_grant[1]) w_rr_next = LAST_B;
  end

  assign w_sel_data = w_grant[1] ? w_hold_data[1] : w_hold_data[0];
  assign w_sel_user = w_grant[1] ? w_hold_user[1] : w_hold_user[0];

  // Issue stage: drive CSC input and launch the tag; din holds when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_din        <= '0;
      r_issue_vld  <= 1'b0;
      r_issue_id   <= 1'b0;
      r_issue_user <= '0;
    end else if (|w_grant) begin
      r_din        <= w_sel_data;
      r_issue_vld  <= 1'b1;
      r_issue_id   <= w_grant[1];
      r_issue_user <= w_sel_user;
    end else begin
      r_issue_vld  <= 1'b0;
    end
  end

  assign csc_din0 = r_din[DW-1:0];
  assign csc_din1 = r_din[2*DW-1:DW];
  assign csc_din2 = r_din[3*DW-1:2*DW];

  // Tag pipe: last stage lines up with csc_dout for the same pixel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CSC_LAT; i++) begin
        r_tag_vld[i]  <= 1'b0;
        r_tag_id[i]   <= 1'b0;
        r_tag_user[i] <= '0;
      end
    end else begin
      r_tag_vld[0]  <= r_issue_vld;
      r_tag_id[0]   <= r_issue_id;
      r_tag_user[0] <= r_issue_user;
      for (int i = 1; i < CSC_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_id[i]   <= r_tag_id[i-1];
        r_tag_user[i] <= r_tag_user[i-1];
      end
    end
  end

  assign w_dout = {csc_dout2, csc_dout1, csc_dout0};

  // Per-port output registers
  generate
    for (gi = 0; gi < NP; gi++) begin : g_out
      logic            r_valid;
      logic [3*DW-1:0] r_data;
      logic [UW-1:0]   r_user;

      assign w_out_valid[gi] = r_valid;
      assign w_out_data[gi]  = r_data;
      assign w_out_user[gi]  = r_user;

      // Strobe for one cycle when the tag targets this port; else hold data
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_user  <= '0;
        end else if (r_tag_vld[CSC_LAT-1] && (r_tag_id[CSC_LAT-1] == 1'(gi))) begin
          r_valid <= 1'b1;
          r_data  <= w_dout;
          r_user  <= r_tag_user[CSC_LAT-1];
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign a_out_valid = w_out_valid[0];
  assign a_out_data  = w_out_data[0];
  assign a_out_user  = w_out_user[0];
  assign b_out_valid = w_out_valid[1];
  assign b_out_data  = w_out_data[1];
  assign b_out_user  = w_out_user[1];

endmodule

// File: tb/tb_csc_share_arb.sv
// Testbench for csc_share_arb: directed vectors with a queue scoreboard and
// a CSC stub that is a pure CSC_LAT-cycle delay.
`timescale 1ns/1ps
module tb_csc_share_arb;
  parameter int CSC_LAT = 4;
  localparam int DW = 12;
  localparam int UW = 3;

  typedef struct {
    logic [3*DW-1:0] data;
    logic [UW-1:0]   user;
    int              cyc;   // required output cycle, -1 = any
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [3*DW-1:0] a_data, b_data;
  logic [UW-1:0]   a_user, b_user;
  logic            a_valid, b_valid, a_ready, b_ready;
  logic [DW-1:0]   csc_din0, csc_din1, csc_din2;
  logic [DW-1:0]   csc_dout0, csc_dout1, csc_dout2;
  logic [3*DW-1:0] a_out_data, b_out_data;
  logic [UW-1:0]   a_out_user, b_out_user;
  logic            a_out_valid, b_out_valid;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   abort = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  csc_share_arb #(.DW(DW), .CSC_LAT(CSC_LAT), .UW(UW)) dut (
    .clk(clk), .rstn(rstn),
    .a_data(a_data), .a_user(a_user), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .csc_din0(csc_din0), .csc_din1(csc_din1), .csc_din2(csc_din2),
    .csc_dout0(csc_dout0), .csc_dout1(csc_dout1), .csc_dout2(csc_dout2),
    .a_out_data(a_out_data), .a_out_user(a_out_user), .a_out_valid(a_out_valid),
    .b_out_data(b_out_data), .b_out_user(b_out_user), .b_out_valid(b_out_valid)
  );

  always #5 clk = ~clk;

  // Edge counter: at #1 after edge n (and at the following negedge) cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // CSC stub: pure delay of CSC_LAT clocks
  logic [3*DW-1:0] stub [CSC_LAT];
  always @(posedge clk) begin
    stub[0] <= {csc_din2, csc_din1, csc_din0};
    for (int i = 1; i < CSC_LAT; i++) stub[i] <= stub[i-1];
  end
  assign {csc_dout2, csc_dout1, csc_dout0} = stub[CSC_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor side of the scoreboard
  task automatic check_out(input bit p, input logic [3*DW-1:0] d, input logic [UW-1:0] u);
    exp_t  e;
    string pn;
    pn = p ? "B" : "A";
    checks++;
    if ((p && qb.size() == 0) || (!p && qa.size() == 0)) begin
      errors++;
      $display("FAIL out_%s unexpected: data=%h user=%b cycle=%0d required no output", pn, d, u, cyc);
      return;
    end
    if (p) e = qb.pop_front();
    else   e = qa.pop_front();
    if (d !== e.data || u !== e.user || (e.cyc >= 0 && cyc != e.cyc)) begin
      errors++;
      $display("FAIL out_%s: data=%h user=%b cycle=%0d required data=%h user=%b cycle=%0d",
               pn, d, u, cyc, e.data, e.user, e.cyc);
    end else begin
      $display("ok   out_%s data=%h user=%b cycle=%0d", pn, d, u, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (a_out_valid) check_out(1'b0, a_out_data, a_out_user);
      if (b_out_valid) check_out(1'b1, b_out_data, b_out_user);
    end
  end

  // Stimulus side: offer one pixel, push the expectation on the accept edge
  task automatic drive(input bit p, input logic [3*DW-1:0] d, input logic [UW-1:0] u,
                       input bit push, input int extra);
    exp_t e;
    bit   hs;
    int   n;
    if (abort) return;
    if (p) begin b_data = d; b_user = u; b_valid = 1'b1; end
    else   begin a_data = d; a_user = u; a_valid = 1'b1; end
    hs = 1'b0;
    n  = 0;
    while (!hs) begin
      @(negedge clk);
      if (abort) break;
      hs = p ? b_ready : a_ready;
      if (hs && push) begin
        e.data = d;
        e.user = u;
        e.cyc  = (extra < 0) ? -1 : cyc + 1 + 2 + CSC_LAT + extra;
        if (p) qb.push_back(e);
        else   qa.push_back(e);
      end
      @(posedge clk); #1;
      n++;
      if (!hs && n > 1000) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout port=%0d: ready=0 for %0d cycles required 1", p, n);
        break;
      end
    end
    if (p) b_valid = 1'b0;
    else   a_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qa.size() + qb.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({"drain_", name}, 64'(qa.size() + qb.size()), 64'd0);
  endtask

  function automatic logic [3*DW-1:0] pix(input int base);
    return {12'(base + 2), 12'(base + 1), 12'(base)};
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low;
    int n_out;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; a_user = '0; b_user = '0;
    rstn = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {62'd0, b_ready, a_ready}, 64'd0);
    chk("rst_out_valid", {62'd0, b_out_valid, a_out_valid}, 64'd0);
    chk("rst_csc_din", {28'd0, csc_din2, csc_din1, csc_din0}, 64'd0);
    chk("rst_out_data", {a_out_data[27:0], b_out_data}, 64'd0);
    chk("rst_out_user", {58'd0, a_out_user, b_out_user}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {62'd0, b_ready, a_ready}, 64'h3);

    // Single pixel on A, then on B: exact latency, no cross-port output
    drive(1'b0, {12'h789, 12'h456, 12'h123}, 3'b001, 1'b1, 0);
    drain("single_a");
    drive(1'b1, {12'hABC, 12'h0F0, 12'h00F}, 3'b110, 1'b1, 0);
    drain("single_b");

    // Both ports stream 8 pixels from the same cycle: A0,B0,A1,B1,...
    fork
      for (int i = 0; i < 8; i++) drive(1'b0, pix(12'h010 + i), 3'(i), 1'b1, (i == 0) ? 0 : 1);
      for (int i = 0; i < 8; i++) drive(1'b1, pix(12'h800 + i), 3'(7 - i), 1'b1, 1);
      begin
        @(negedge clk);
        for (int j = 1; j <= 12; j++) begin
          @(negedge clk);
          chk($sformatf("dual_ready_%0d", j), {62'd0, b_ready, a_ready},
              (j % 2 == 1) ? 64'h1 : 64'h2);
        end
      end
    join
    drain("dual");

    // Only B streams 100 pixels: ready never drops, outputs back-to-back
    n_low = 0;
    fork
      for (int i = 0; i < 100; i++) drive(1'b1, pix(12'h400 + i), 3'(i), 1'b1, 0);
      for (int j = 0; j < 100; j++) begin
        @(negedge clk);
        if (!b_ready) n_low++;
      end
    join
    chk("b_stream_ready_low_cycles", 64'(n_low), 64'd0);
    drain("b_stream");

    // Random 50% valid on both ports, sequence numbers in c0/c1
    fork
      for (int i = 0; i < 5000; i++) begin
        if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
        drive(1'b0, {12'($urandom), 12'(i >> 12), 12'(i)}, 3'($urandom), 1'b1, -1);
      end
      for (int i = 0; i < 5000; i++) begin
        if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
        drive(1'b1, {12'($urandom), 12'(i >> 12), 12'(i)}, 3'($urandom), 1'b1, -1);
      end
    join
    drain("random");

    // Reset while pixels are in flight: they must vanish
    fork
      for (int i = 0; i < 3; i++) drive(1'b0, pix(12'h100 + 4 * i), 3'b011, 1'b0, -1);
      for (int i = 0; i < 2; i++) drive(1'b1, pix(12'h200 + 4 * i), 3'b101, 1'b0, -1);
      begin
        @(negedge clk); @(negedge clk); @(negedge clk);
        abort = 1'b1;
        rstn = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("async_rst_ready", {62'd0, b_ready, a_ready}, 64'd0);
        chk("async_rst_out_valid", {62'd0, b_out_valid, a_out_valid}, 64'd0);
        chk("async_rst_csc_din", {28'd0, csc_din2, csc_din1, csc_din0}, 64'd0);
        chk("async_rst_a_out", {25'd0, a_out_user, a_out_data}, 64'd0);
        chk("async_rst_b_out", {25'd0, b_out_user, b_out_data}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
      end
    join
    abort = 1'b0;
    n_out = 0;
    repeat (CSC_LAT + 6) begin
      @(negedge clk);
      n_out += int'(a_out_valid) + int'(b_out_valid);
    end
    chk("post_rst_no_stale_out", 64'(n_out), 64'd0);

    // After reset, simultaneous first pixels: A issued first
    @(posedge clk); #1;
    fork
      drive(1'b0, pix(12'h321), 3'b010, 1'b1, 0);
      drive(1'b1, pix(12'h654), 3'b100, 1'b1, 1);
    join
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
